// File: rtl/reg_file_2r1w.sv
// Register file with one byte-enabled write port and two registered read ports.
// Same-cycle read/write of one address returns the merged (write-first) word.
module reg_file_2r1w #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  re_a,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  re_b,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  rd_valid_b
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word_a;
    logic [DATA_W-1:0] rd_word_b;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            wr_mask[8*i +: 8] = {8{wr_be[i]}};
        end
    end

    // Merged word serves both the array update and the write-first bypass;
    // with wr_be=0 it equals the old entry, so the write becomes a no-op.
    assign wr_word   = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    assign rd_word_a = (we && (wr_addr == rd_addr_a)) ? wr_word : mem[rd_addr_a];
    assign rd_word_b = (we && (wr_addr == rd_addr_b)) ? wr_word : mem[rd_addr_b];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
        end else begin
            rd_valid_a <= re_a;
            if (re_a) begin
                rd_data_a <= rd_word_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_b <= re_b;
            if (re_b) begin
                rd_data_b <= rd_word_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a reference memory model feeds per-port scoreboards
// that are drained by a negedge monitor; tasks add directed inline checks.
module tb_reg_file_2r1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam logic [31:0] RVAL = 32'h0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        re_a;
    logic [2:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic        rd_valid_a;
    logic        re_b;
    logic [2:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        rd_valid_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] model [8];
    exp_t qa[$];
    exp_t qb[$];

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(RVAL)) dut (
        .clk(clk), .reset_n(reset_n),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .re_a(re_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .re_b(re_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: each expectation must appear exactly on its cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_valid_a) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL port_a_unexpected: rd_valid_a=1 data=%h, required no strobe", rd_data_a);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    if (rd_data_a !== e.data || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL port_a_data: got %h at cycle %0d, required %h at cycle %0d",
                                 rd_data_a, cyc, e.data, e.cyc);
                    end
                end
            end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL port_a_missing: rd_valid_a=0 at cycle %0d, required 1 with %h", cyc, qa[0].data);
                void'(qa.pop_front());
            end
            if (rd_valid_b) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL port_b_unexpected: rd_valid_b=1 data=%h, required no strobe", rd_data_b);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    if (rd_data_b !== e.data || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL port_b_data: got %h at cycle %0d, required %h at cycle %0d",
                                 rd_data_b, cyc, e.data, e.cyc);
                    end
                end
            end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL port_b_missing: rd_valid_b=0 at cycle %0d, required 1 with %h", cyc, qb[0].data);
                void'(qb.pop_front());
            end
        end
    end

    // Drives one cycle of stimulus just after a rising edge, updates the model
    // write-first and records the expected read words.
    task automatic drive(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic ra, input logic [2:0] aa,
                         input logic rb, input logic [2:0] ab);
        we = w; wr_addr = wa; wr_data = wd; wr_be = be;
        re_a = ra; rd_addr_a = aa; re_b = rb; rd_addr_b = ab;
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (ra) qa.push_back('{model[aa], cyc + 1});
        if (rb) qb.push_back('{model[ab], cyc + 1});
        @(posedge clk); #1;
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; wr_be = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        we = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        re_a = 0; rd_addr_a = 0; re_b = 0; rd_addr_b = 0;
        for (int i = 0; i < 8; i++) model[i] = RVAL;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got a=%b b=%b, required 0 0", rd_valid_a, rd_valid_b);
        end
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h, required 0 0", rd_data_a, rd_data_b);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, 3'(k), 0, 0);
        idle(1);
    endtask

    task automatic test_fill_dual;
        for (int k = 0; k < 8; k++) drive(1, 3'(k), 32'h1111_1111 * (k + 1), 4'hF, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1, 3'(k), 1, 3'(7 - k));
            checks++;
            if (rd_data_a !== 32'h1111_1111 * (k + 1) || rd_data_b !== 32'h1111_1111 * (8 - k)) begin
                errors++;
                $display("FAIL dual_read k=%0d: got a=%h b=%h, required a=%h b=%h", k, rd_data_a,
                         rd_data_b, 32'h1111_1111 * (k + 1), 32'h1111_1111 * (8 - k));
            end
        end
        idle(1);
    endtask

    task automatic test_byte_enable;
        drive(1, 3, 32'h4444_4444, 4'hF, 0, 0, 0, 0);
        drive(1, 3, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 0);
        drive(1, 1, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 1, 1);
        checks++;
        if (rd_data_a !== 32'h44BB_44DD) begin
            errors++;
            $display("FAIL byte_enable: got %h, required 44bb44dd", rd_data_a);
        end
        checks++;
        if (rd_data_b !== 32'h2222_2222) begin
            errors++;
            $display("FAIL be_zero_noop: got %h, required 22222222", rd_data_b);
        end
        idle(1);
    endtask

    task automatic test_bypass;
        drive(1, 2, 32'hDEAD_BEEF, 4'hF, 1, 2, 1, 4);
        checks++;
        if (rd_data_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass: got %h, required deadbeef", rd_data_a);
        end
        checks++;
        if (rd_data_b !== 32'h5555_5555) begin
            errors++;
            $display("FAIL other_addr_old: got %h, required 55555555", rd_data_b);
        end
        drive(1, 6, 32'h1234_5678, 4'b1100, 1, 6, 1, 6);
        idle(1);
    endtask

    task automatic test_back_to_back;
        drive(1, 6, 32'h7777_7777, 4'hF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        idle(1);
        checks++;
        if (rd_valid_a !== 1'b0 || rd_data_a !== 32'h8888_8888) begin
            errors++;
            $display("FAIL hold: got valid=%b data=%h, required valid=0 data=88888888", rd_valid_a, rd_data_a);
        end
        idle(2);
        checks++;
        if (rd_data_a !== 32'h8888_8888) begin
            errors++;
            $display("FAIL hold_long: got %h, required 88888888", rd_data_a);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        idle(2);
    endtask

    task automatic test_reset_midstream;
        drive(0, 0, 0, 0, 1, 1, 1, 2);
        #2;
        we = 1'b1; wr_addr = 6; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got a=%b b=%b, required 0 0", rd_valid_a, rd_valid_b);
        end
        checks++;
        if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_data: got a=%h b=%h, required 0 0", rd_data_a, rd_data_b);
        end
        qa.delete();
        qb.delete();
        for (int i = 0; i < 8; i++) model[i] = RVAL;
        repeat (2) @(posedge clk);
        #1;
        we = 1'b0; wr_be = 4'h0;
        reset_n = 1'b1;
        idle(2);
        for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, 3'(k), 1, 3'(7 - k));
        checks++;
        if (rd_data_a !== RVAL) begin
            errors++;
            $display("FAIL write_lost_in_reset: got %h, required %h", rd_data_a, RVAL);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_fill_dual();
        test_byte_enable();
        test_bypass();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        idle(2);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
